// File: rtl/fetch_redirect_ctrl.sv
// fetch_redirect_ctrl
// Arbitrates PC redirect sources (ROB commit redirect, EX branch redirect,
// branch-predictor target) for the fetch stage. Every accepted redirect
// produces a one-cycle flush pulse with its target and bumps the flush epoch.
// After a flush, fetch is held stalled for FLUSH_HOLD drain cycles.
//
// state | meaning
// ------+---------------------------------------------------------------
// RUN   | normal fetch; predictor targets are forwarded; EX/ROB accepted
// HOLD  | post-flush drain; stall forced; only ROB redirects accepted
//
// XLEN mirrors the value in general_defines so this file stands alone.
module fetch_redirect_ctrl #(
  parameter int FLUSH_HOLD = 2,
  parameter int EPOCH_W    = 3,
  localparam int XLEN      = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rob_redir_valid,
  input  logic [XLEN-1:0]    rob_redir_pc,
  input  logic               ex_redir_valid,
  input  logic [XLEN-1:0]    ex_redir_pc,
  input  logic               bp_pred_valid,
  input  logic [XLEN-1:0]    bp_pred_pc,
  input  logic               backend_stall,
  output logic               pred_valid,
  output logic [XLEN-1:0]    pred_pc,
  output logic               stall,
  output logic               flush,
  output logic [XLEN-1:0]    flush_pc,
  output logic [EPOCH_W-1:0] flush_epoch,
  output logic               hold_active
);

  localparam int CNT_W = (FLUSH_HOLD < 1) ? 1 : $clog2(FLUSH_HOLD + 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(FLUSH_HOLD);

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] hold_cnt;

  logic             ex_acc;
  logic             redir_acc;
  logic [XLEN-1:0]  redir_pc;

  // Redirect arbitration: ROB always wins; EX is wrong-path during HOLD or the flush cycle.
  always_comb begin
    ex_acc    = ex_redir_valid && (state == RUN) && !flush;
    redir_acc = rob_redir_valid || ex_acc;
    redir_pc  = rob_redir_valid ? rob_redir_pc : ex_redir_pc;
  end

  // Flush pulse, epoch tag and drain-window sequencing.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      hold_cnt    <= '0;
      flush       <= 1'b0;
      flush_pc    <= '0;
      flush_epoch <= '0;
    end else begin
      flush <= redir_acc;
      if (redir_acc) begin
        flush_pc    <= redir_pc;
        flush_epoch <= flush_epoch + EPOCH_W'(1);
      end
      if (redir_acc && (FLUSH_HOLD > 0)) begin
        state    <= HOLD;
        hold_cnt <= HOLD_LOAD;
      end else if ((state == HOLD) && !flush) begin
        hold_cnt <= hold_cnt - CNT_W'(1);
        if (hold_cnt == CNT_W'(1)) begin
          state <= RUN;
        end
      end
    end
  end

  // Fetch-side controls; the fetch stage gives flush priority over stall.
  always_comb begin
    hold_active = (state == HOLD);
    stall       = backend_stall || (state == HOLD);
    pred_valid  = bp_pred_valid && (state == RUN) && !flush && !backend_stall;
    pred_pc     = bp_pred_pc;
  end

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Scoreboard bench for fetch_redirect_ctrl. Two instances (FLUSH_HOLD=2 and
// FLUSH_HOLD=0) see the same stimulus. The reference model tracks each
// instance's drain window as an absolute "hold ends at cycle" timestamp.
module tb_fetch_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        rob_redir_valid;
  logic [31:0] rob_redir_pc;
  logic        ex_redir_valid;
  logic [31:0] ex_redir_pc;
  logic        bp_pred_valid;
  logic [31:0] bp_pred_pc;
  logic        backend_stall;

  logic        pv0, st0, fl0, ha0, pv1, st1, fl1, ha1;
  logic [31:0] pp0, fpc0, pp1, fpc1;
  logic [2:0]  ep0, ep1;

  always #5 clk = ~clk;

  fetch_redirect_ctrl #(.FLUSH_HOLD(2), .EPOCH_W(3)) u_h2 (
    .clk(clk), .rst(rst),
    .rob_redir_valid(rob_redir_valid), .rob_redir_pc(rob_redir_pc),
    .ex_redir_valid(ex_redir_valid), .ex_redir_pc(ex_redir_pc),
    .bp_pred_valid(bp_pred_valid), .bp_pred_pc(bp_pred_pc),
    .backend_stall(backend_stall),
    .pred_valid(pv0), .pred_pc(pp0), .stall(st0), .flush(fl0),
    .flush_pc(fpc0), .flush_epoch(ep0), .hold_active(ha0)
  );

  fetch_redirect_ctrl #(.FLUSH_HOLD(0), .EPOCH_W(3)) u_h0 (
    .clk(clk), .rst(rst),
    .rob_redir_valid(rob_redir_valid), .rob_redir_pc(rob_redir_pc),
    .ex_redir_valid(ex_redir_valid), .ex_redir_pc(ex_redir_pc),
    .bp_pred_valid(bp_pred_valid), .bp_pred_pc(bp_pred_pc),
    .backend_stall(backend_stall),
    .pred_valid(pv1), .pred_pc(pp1), .stall(st1), .flush(fl1),
    .flush_pc(fpc1), .flush_epoch(ep1), .hold_active(ha1)
  );

  typedef struct packed {
    logic        pred_valid;
    logic [31:0] pred_pc;
    logic        stall;
    logic        flush;
    logic [31:0] flush_pc;
    logic [2:0]  epoch;
    logic        hold;
  } out_t;

  typedef struct packed {
    int         cyc;
    out_t [1:0] o;
  } exp_t;

  exp_t q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Reference model state, one slot per instance.
  int          fh [2] = '{2, 0};
  int          m_epoch [2];
  int          m_hold_end [2];
  bit          m_flush [2];
  logic [31:0] m_fpc [2];

  task automatic chk(input string name, input int c, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req)
      $display("FAIL %s cycle=%0d actual=0x%0h required=0x%0h", name, c, act, req);
    else
      n_pass++;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_epoch[i]    = 0;
      m_hold_end[i] = -100;
      m_flush[i]    = 1'b0;
      m_fpc[i]      = '0;
    end
  endtask

  // Apply one cycle of inputs, push the expected outputs, advance the model.
  task automatic step(input bit r, input bit rv, input logic [31:0] rp,
                      input bit ev, input logic [31:0] ep,
                      input bit bv, input logic [31:0] bp, input bit bs);
    exp_t e;
    bit   hold;
    bit   acc;
    rst = r; rob_redir_valid = rv; rob_redir_pc = rp;
    ex_redir_valid = ev; ex_redir_pc = ep;
    bp_pred_valid = bv; bp_pred_pc = bp; backend_stall = bs;
    e.cyc = cyc;
    for (int i = 0; i < 2; i++) begin
      hold = (fh[i] > 0) && (cyc <= m_hold_end[i]);
      e.o[i].pred_valid = bv && !hold && !m_flush[i] && !bs;
      e.o[i].pred_pc    = bp;
      e.o[i].stall      = bs || hold;
      e.o[i].flush      = m_flush[i];
      e.o[i].flush_pc   = m_fpc[i];
      e.o[i].epoch      = 3'(m_epoch[i]);
      e.o[i].hold       = hold;
      if (!r) begin
        acc = rv || (ev && !hold && !m_flush[i]);
        if (acc) begin
          m_fpc[i]      = rv ? rp : ep;
          m_epoch[i]    = (m_epoch[i] + 1) % 8;
          m_hold_end[i] = cyc + 1 + fh[i];
        end
        m_flush[i] = acc;
      end
    end
    if (r) model_reset();
    q.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n, input bit bv);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, bv, 32'h100, 0);
  endtask

  // Monitor: the DUT presents its outputs every cycle; compare mid-cycle.
  initial begin
    exp_t e;
    out_t a [2];
    string tag;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        a[0] = {pv0, pp0, st0, fl0, fpc0, ep0, ha0};
        a[1] = {pv1, pp1, st1, fl1, fpc1, ep1, ha1};
        for (int i = 0; i < 2; i++) begin
          tag = (i == 0) ? "h2" : "h0";
          chk({tag, ".pred_valid"},  e.cyc, 64'(a[i].pred_valid), 64'(e.o[i].pred_valid));
          chk({tag, ".pred_pc"},     e.cyc, 64'(a[i].pred_pc),    64'(e.o[i].pred_pc));
          chk({tag, ".stall"},       e.cyc, 64'(a[i].stall),      64'(e.o[i].stall));
          chk({tag, ".flush"},       e.cyc, 64'(a[i].flush),      64'(e.o[i].flush));
          chk({tag, ".flush_pc"},    e.cyc, 64'(a[i].flush_pc),   64'(e.o[i].flush_pc));
          chk({tag, ".flush_epoch"}, e.cyc, 64'(a[i].epoch),      64'(e.o[i].epoch));
          chk({tag, ".hold_active"}, e.cyc, 64'(a[i].hold),       64'(e.o[i].hold));
        end
      end
    end
  end

  // Stimulus: directed scenarios first, then randomized traffic.
  initial begin
    rst = 1'b1; rob_redir_valid = 0; rob_redir_pc = 0; ex_redir_valid = 0;
    ex_redir_pc = 0; bp_pred_valid = 0; bp_pred_pc = 0; backend_stall = 0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    idle(3, 0);
    idle(1, 1);
    // EX redirect, predictor held valid through the drain window
    step(0, 0, 0, 1, 32'h2000, 1, 32'h100, 0);
    idle(5, 1);
    // ROB and EX together: ROB wins
    step(0, 1, 32'h400, 1, 32'h800, 0, 0, 0);
    // EX in flush cycle and HOLD is ignored; ROB in HOLD restarts the hold
    step(0, 0, 0, 1, 32'h1111, 0, 0, 0);
    step(0, 0, 0, 1, 32'h2222, 0, 0, 0);
    step(0, 1, 32'h900, 0, 0, 1, 32'h100, 0);
    idle(5, 1);
    // Eight back-to-back ROB redirects wrap the 3-bit epoch
    for (int k = 0; k < 8; k++) step(0, 1, 32'h1000 + 32'(k * 4), 0, 0, 0, 0, 0);
    idle(5, 0);
    // Reset in the middle of HOLD with backend_stall high
    step(0, 1, 32'hA00, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 1, 32'h100, 1);
    step(0, 0, 0, 0, 0, 1, 32'h100, 1);
    idle(3, 1);

    for (int k = 0; k < 600; k++) begin
      step($urandom_range(0, 49) == 0,
           $urandom_range(0, 11) == 0, $urandom & 32'hFFFF_FFFC,
           $urandom_range(0, 5) == 0,  $urandom & 32'hFFFF_FFFC,
           $urandom_range(0, 1) == 1,  $urandom & 32'hFFFF_FFFC,
           $urandom_range(0, 3) == 0);
    end
    idle(4, 0);

    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", cyc, 64'(q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
